// File: rtl/mcycle_gen.sv
// Multi-cycle multiply/divide unit: one shift-add or restoring shift-subtract
// step per cycle on operand magnitudes, sign correction applied in FINISH.
module mcycle_gen #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             Start,
    input  logic [1:0]       MCycleOp,
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, FINISH} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               zero_q, zero_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [WIDTH-1:0]   dv_q, dv_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   res1_q, res1_d;
    logic [WIDTH-1:0]   res2_q, res2_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               sgn, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     sum, sh;
    logic [2*WIDTH-1:0] prod, prod_s;

    always_comb begin
        sgn   = ~MCycleOp[0];
        a_neg = sgn & Operand1[WIDTH-1];
        b_neg = sgn & Operand2[WIDTH-1];
        a_mag = a_neg ? -Operand1 : Operand1;
        b_mag = b_neg ? -Operand2 : Operand2;
        // mul: {rem,quo} is the running product, quo starts as the multiplier
        sum   = {1'b0, rem_q} + (quo_q[0] ? {1'b0, dv_q} : '0);
        // div: rem:quo shifts left one bit, quotient bits enter at the bottom
        sh    = {rem_q, quo_q[WIDTH-1]};
        prod  = {rem_q, quo_q};
        prod_s = q_neg_q ? -prod : prod;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        zero_d   = zero_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        dv_d     = dv_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        res1_d   = res1_q;
        res2_d   = res2_q;
        dz_d     = dz_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    is_div_d = MCycleOp[1];
                    zero_d   = MCycleOp[1] && (Operand2 == '0);
                    q_neg_d  = a_neg ^ b_neg;
                    r_neg_d  = a_neg;
                    cnt_d    = CW'(WIDTH);
                    rem_d    = '0;
                    dv_d     = MCycleOp[1] ? b_mag : a_mag;
                    quo_d    = MCycleOp[1] ? a_mag : b_mag;
                    if (MCycleOp[1] && (Operand2 == '0)) begin
                        // raw dividend rides in quo to become the remainder
                        quo_d   = Operand1;
                        state_d = FINISH;
                    end else begin
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                if (is_div_q) begin
                    if (sh >= {1'b0, dv_q}) begin
                        rem_d = WIDTH'(sh - {1'b0, dv_q});
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = sh[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    rem_d = sum[WIDTH:1];
                    quo_d = {sum[0], quo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) state_d = FINISH;
            end
            FINISH: begin
                done_d  = 1'b1;
                dz_d    = zero_q;
                state_d = IDLE;
                if (zero_q) begin
                    res1_d = '1;
                    res2_d = quo_q;
                end else if (is_div_q) begin
                    res1_d = q_neg_q ? -quo_q : quo_q;
                    res2_d = r_neg_q ? -rem_q : rem_q;
                end else begin
                    res1_d = prod_s[WIDTH-1:0];
                    res2_d = prod_s[2*WIDTH-1:WIDTH];
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            zero_q   <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            dv_q     <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            res1_q   <= '0;
            res2_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            zero_q   <= zero_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            dv_q     <= dv_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            res1_q   <= res1_d;
            res2_q   <= res2_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign Result1   = res1_q;
    assign Result2   = res2_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign DivByZero = dz_q;

endmodule

// File: tb/tb_mcycle_gen.sv
// Scoreboard bench for mcycle_gen at WIDTH=4: stimulus queues expected results,
// a negedge monitor checks them on every Done pulse.
module tb_mcycle_gen;
    localparam int W = 4;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         Start;
    logic [1:0]   MCycleOp;
    logic [W-1:0] Operand1, Operand2;
    logic [W-1:0] Result1, Result2;
    logic         Busy, Done, DivByZero;

    typedef struct {
        logic [W-1:0] r1;
        logic [W-1:0] r2;
        logic         dz;
        int           bc;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           passed = 0;
    int           done_cnt = 0;
    int           busy_cnt = 0;
    int           stab_bad = 0;
    logic [W-1:0] last_r1 = '0, last_r2 = '0;

    mcycle_gen #(.WIDTH(W)) dut (
        .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
        .Operand1(Operand1), .Operand2(Operand2),
        .Result1(Result1), .Result2(Result2),
        .Busy(Busy), .Done(Done), .DivByZero(DivByZero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) $display("FAIL %s actual=%0h required=%0h", name, act, req);
        else passed++;
    endtask

    // monitor / scoreboard
    always @(negedge CLK) begin
        exp_t e;
        if (!RESET) begin
            busy_cnt = 0;
            last_r1  = Result1;
            last_r2  = Result2;
        end else begin
            if (Done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done_cnt), 32'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("result1", 32'(Result1), 32'(e.r1));
                    chk("result2", 32'(Result2), 32'(e.r2));
                    chk("divbyzero", 32'(DivByZero), 32'(e.dz));
                    chk("busy_cycles", 32'(busy_cnt), 32'(e.bc));
                end
                busy_cnt = 0;
                last_r1  = Result1;
                last_r2  = Result2;
            end else if (Result1 !== last_r1 || Result2 !== last_r2) begin
                stab_bad++;
            end
            if (Busy) busy_cnt++;
        end
    end

    task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
    endtask

    task automatic wait_done(input int target);
        int n;
        n = 0;
        while (done_cnt < target && n < 40) begin
            @(posedge CLK); #1;
            n++;
        end
        if (done_cnt < target) begin
            checks++;
            $display("FAIL done_timeout actual=%0d required=%0d", done_cnt, target);
            exp_q.delete();
            done_cnt = target;
        end
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] r1, input logic [W-1:0] r2,
                          input logic dz, input int bc);
        int tgt;
        tgt = done_cnt + 1;
        exp_q.push_back('{r1, r2, dz, bc});
        issue(op, a, b);
        @(posedge CLK); #1;
        // junk on the inputs while busy must not disturb the latched op
        Start    = 1'b0;
        MCycleOp = ~op;
        Operand1 = ~a;
        Operand2 = ~b;
        wait_done(tgt);
        @(posedge CLK); #1;
    endtask

    initial begin
        int tgt;
        RESET = 1'b0; Start = 1'b0; MCycleOp = '0; Operand1 = '0; Operand2 = '0;
        #12;
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_dz", 32'(DivByZero), 0);
        chk("rst_r1", 32'(Result1), 0);
        chk("rst_r2", 32'(Result2), 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("no_start_after_rst", 32'(Busy), 0);

        run_op(2'b00, 4'b1111, 4'b1111, 4'b0001, 4'b0000, 1'b0, 5);
        run_op(2'b00, 4'b0111, 4'b1000, 4'b1000, 4'b1100, 1'b0, 5);

        // back-to-back unsigned muls with Start held high
        tgt = done_cnt + 1;
        exp_q.push_back('{4'b0001, 4'b1110, 1'b0, 5});
        exp_q.push_back('{4'b0010, 4'b1101, 1'b0, 5});
        issue(2'b01, 4'b1111, 4'b1111);
        @(posedge CLK); #1;
        Operand1 = 4'b1110;
        wait_done(tgt);
        Start = 1'b0;
        Operand1 = 4'b0101;
        wait_done(tgt + 1);
        @(posedge CLK); #1;

        run_op(2'b11, 4'b0111, 4'b0010, 4'b0011, 4'b0001, 1'b0, 5);
        run_op(2'b10, 4'b1000, 4'b0010, 4'b1100, 4'b0000, 1'b0, 5);
        run_op(2'b10, 4'b1000, 4'b1111, 4'b1000, 4'b0000, 1'b0, 5);
        run_op(2'b10, 4'b1001, 4'b0010, 4'b1101, 4'b1111, 1'b0, 5);
        run_op(2'b10, 4'b0111, 4'b1110, 4'b1101, 4'b0001, 1'b0, 5);
        run_op(2'b11, 4'b0110, 4'b0000, 4'b1111, 4'b0110, 1'b1, 1);
        repeat (3) @(posedge CLK);
        #1;
        chk("dz_held", 32'(DivByZero), 1);

        // reset in the middle of a multiply
        issue(2'b01, 4'b0111, 4'b0101);
        @(posedge CLK); #1;
        Start = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #2 RESET = 1'b0;
        #1;
        chk("abort_busy", 32'(Busy), 0);
        chk("abort_done", 32'(Done), 0);
        chk("abort_dz", 32'(DivByZero), 0);
        chk("abort_r1", 32'(Result1), 0);
        chk("abort_r2", 32'(Result2), 0);
        @(posedge CLK); #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk("abort_idle", 32'(Busy), 0);
        run_op(2'b00, 4'b0011, 4'b0010, 4'b0110, 4'b0000, 1'b0, 5);

        repeat (3) @(posedge CLK);
        #1;
        chk("queue_empty", 32'(exp_q.size()), 0);
        chk("result_stable", 32'(stab_bad), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
